// File: rtl/mem_pkg.sv
// Shared defaults, latency-counter sizing and the FSM state type for the
// parameterised memory slave.
package mem_pkg;

   localparam int DEF_WIDTH      = 32;
   localparam int DEF_ADDR_WIDTH = 8;
   localparam int DEF_DEPTH      = 256;
   localparam int DEF_RD_LATENCY = 2;

   // RD_LATENCY tops out at 4, so the wait counter never has to hold more than 2
   localparam int CNT_W = 2;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RD_WAIT = 2'd1,
      ST_RD_RESP = 2'd2
   } state_e;

   function automatic logic [CNT_W-1:0] wait_load(input int rd_latency);
      logic [CNT_W-1:0] val;
      if (rd_latency > 1) begin
         val = CNT_W'(rd_latency - 2);
      end else begin
         val = '0;
      end
      return val;
   endfunction

endpackage

// File: rtl/mem_array.sv
// Word-addressed storage with a byte-strobed write port and a registered read
// port. The array itself has no reset, so its contents survive rst_i.
module mem_array
   import mem_pkg::*;
#(
   parameter int WIDTH      = DEF_WIDTH,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int DEPTH      = DEF_DEPTH
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  we_i,
   input  logic [ADDR_WIDTH-1:0] waddr_i,
   input  logic [WIDTH-1:0]      wdata_i,
   input  logic [WIDTH/8-1:0]    strb_i,
   input  logic                  re_i,
   input  logic [ADDR_WIDTH-1:0] raddr_i,
   output logic [WIDTH-1:0]      rdata_o
);

   localparam int NB = WIDTH / 8;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] rdata_q;
   logic [WIDTH-1:0] rdata_d;

   always_ff @(posedge clk_i) begin
      for (int b = 0; b < NB; b++) begin
         if (we_i && strb_i[b]) begin
            mem_q[waddr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
         end
      end
   end

   // Read data is captured once at the accepting edge and then held.
   always_comb begin
      rdata_d = rdata_q;
      if (re_i) begin
         rdata_d = mem_q[raddr_i];
      end else begin
         rdata_d = rdata_q;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rdata_q <= '0;
      end else begin
         rdata_q <= rdata_d;
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/param_mem_slave.sv
// Single-port memory slave: zero-wait strobed writes, fixed-latency reads with
// a one-cycle rvalid/err response, and an address range check against DEPTH.
module param_mem_slave
   import mem_pkg::*;
#(
   parameter int WIDTH      = DEF_WIDTH,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int DEPTH      = DEF_DEPTH,
   parameter int RD_LATENCY = DEF_RD_LATENCY
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  valid_i,
   input  logic                  wr_rd_en_i,
   input  logic [ADDR_WIDTH-1:0] addr_i,
   input  logic [WIDTH-1:0]      wdata_i,
   input  logic [WIDTH/8-1:0]    strb_i,
   output logic                  ready_o,
   output logic [WIDTH-1:0]      rdata_o,
   output logic                  rvalid_o,
   output logic                  err_o
);

   state_e           state_q;
   state_e           state_d;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic             ready_q;
   logic             ready_d;
   logic             rvalid_q;
   logic             rvalid_d;
   logic             err_q;
   logic             err_d;
   logic             rd_err_q;
   logic             rd_err_d;

   logic             accept;
   logic             wr_acc;
   logic             rd_acc;
   logic             in_range;
   logic [WIDTH-1:0] mem_rdata;

   // ready is forced low for as long as reset is held
   assign ready_o  = ready_q & ~rst_i;
   assign accept   = valid_i & ready_o;
   assign wr_acc   = accept & wr_rd_en_i;
   assign rd_acc   = accept & ~wr_rd_en_i;
   assign in_range = {1'b0, addr_i} < (ADDR_WIDTH + 1)'(DEPTH);

   mem_array #(
      .WIDTH      (WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .DEPTH      (DEPTH)
   ) u_mem (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .we_i    (wr_acc & in_range),
      .waddr_i (addr_i),
      .wdata_i (wdata_i),
      .strb_i  (strb_i),
      .re_i    (rd_acc & in_range),
      .raddr_i (addr_i),
      .rdata_o (mem_rdata)
   );

   // Next state, wait counter and the registered handshake/response flags.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      rd_err_d = rd_err_q;
      if (rd_acc) begin
         rd_err_d = ~in_range;
      end else begin
         rd_err_d = rd_err_q;
      end
      case (state_q)
         ST_IDLE, ST_RD_RESP: begin
            if (rd_acc) begin
               if (RD_LATENCY == 1) begin
                  state_d = ST_RD_RESP;
               end else begin
                  state_d = ST_RD_WAIT;
                  cnt_d   = wait_load(RD_LATENCY);
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_RD_WAIT: begin
            if (cnt_q == '0) begin
               state_d = ST_RD_RESP;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
      ready_d  = (state_d != ST_RD_WAIT);
      rvalid_d = (state_d == ST_RD_RESP);
      // A write error and a read response can never land in the same cycle.
      err_d    = (wr_acc & ~in_range) | (rvalid_d & rd_err_d);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         ready_q  <= 1'b1;
         rvalid_q <= 1'b0;
         err_q    <= 1'b0;
         rd_err_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         ready_q  <= ready_d;
         rvalid_q <= rvalid_d;
         err_q    <= err_d;
         rd_err_q <= rd_err_d;
      end
   end

   assign rvalid_o = rvalid_q;
   assign err_o    = err_q;
   assign rdata_o  = (rvalid_q && !rd_err_q) ? mem_rdata : '0;

endmodule

// File: tb/tb_param_mem_slave.sv
// Three slave configurations driven by one shared request stream and checked
// every cycle against a timeline model, plus directed literal scenarios.
module tb_param_mem_slave;

   localparam int N = 3;

   logic        clk = 1'b0;
   logic        rst;
   logic        valid;
   logic        wr;
   logic [7:0]  addr;
   logic [31:0] wdata;
   logic [3:0]  strb;

   logic        ready  [N];
   logic        rvalid [N];
   logic        err    [N];
   logic [31:0] rdata  [N];

   always #5 clk = ~clk;

   param_mem_slave #(.WIDTH(32), .ADDR_WIDTH(8), .DEPTH(200), .RD_LATENCY(2)) u_dut0 (
      .clk_i(clk), .rst_i(rst), .valid_i(valid), .wr_rd_en_i(wr), .addr_i(addr),
      .wdata_i(wdata), .strb_i(strb), .ready_o(ready[0]), .rdata_o(rdata[0]),
      .rvalid_o(rvalid[0]), .err_o(err[0]));

   param_mem_slave #(.WIDTH(32), .ADDR_WIDTH(8), .DEPTH(256), .RD_LATENCY(1)) u_dut1 (
      .clk_i(clk), .rst_i(rst), .valid_i(valid), .wr_rd_en_i(wr), .addr_i(addr),
      .wdata_i(wdata), .strb_i(strb), .ready_o(ready[1]), .rdata_o(rdata[1]),
      .rvalid_o(rvalid[1]), .err_o(err[1]));

   param_mem_slave #(.WIDTH(32), .ADDR_WIDTH(8), .DEPTH(256), .RD_LATENCY(4)) u_dut2 (
      .clk_i(clk), .rst_i(rst), .valid_i(valid), .wr_rd_en_i(wr), .addr_i(addr),
      .wdata_i(wdata), .strb_i(strb), .ready_o(ready[2]), .rdata_o(rdata[2]),
      .rvalid_o(rvalid[2]), .err_o(err[2]));

   function automatic int dep_of(input int i);
      return (i == 0) ? 200 : 256;
   endfunction

   function automatic int lat_of(input int i);
      case (i)
         0:       return 2;
         1:       return 1;
         default: return 4;
      endcase
   endfunction

   function automatic logic [31:0] pat(input logic [7:0] a);
      return {16'hC0DE, a, ~a};
   endfunction

   // Model: memory image, one pending response slot, and the number of
   // upcoming cycles in which the slave must refuse requests.
   logic [31:0] mm [N][256];
   int          edge_n = 0;
   int          low_left [N];
   bit          pv   [N];
   int          pdue [N];
   logic [31:0] pdata[N];
   bit          perr [N];
   logic        x_ready  [N];
   logic        x_rvalid [N];
   logic        x_err    [N];
   logic [31:0] x_rdata  [N];

   always @(posedge clk) begin
      bit acc;
      bit oor;
      edge_n++;
      for (int i = 0; i < N; i++) begin
         if (rst) begin
            low_left[i] = 0;
            pv[i]       = 1'b0;
            x_ready[i]  = 1'b1;
            x_rvalid[i] = 1'b0;
            x_err[i]    = 1'b0;
            x_rdata[i]  = 32'h0;
         end else begin
            acc = valid && (low_left[i] == 0);
            oor = (int'(addr) >= dep_of(i));
            if (low_left[i] > 0) low_left[i]--;
            x_rvalid[i] = 1'b0;
            x_err[i]    = 1'b0;
            x_rdata[i]  = 32'h0;
            if (pv[i] && pdue[i] == edge_n) begin
               x_rvalid[i] = 1'b1; x_err[i] = perr[i]; x_rdata[i] = pdata[i]; pv[i] = 1'b0;
            end
            if (acc && wr) begin
               if (oor) x_err[i] = 1'b1;
               else for (int b = 0; b < 4; b++) if (strb[b]) mm[i][addr][b*8 +: 8] = wdata[b*8 +: 8];
            end else if (acc) begin
               pdata[i]    = oor ? 32'h0 : mm[i][addr];
               perr[i]     = oor;
               pdue[i]     = edge_n + lat_of(i) - 1;
               pv[i]       = 1'b1;
               low_left[i] = lat_of(i) - 1;
               if (pdue[i] == edge_n) begin
                  x_rvalid[i] = 1'b1; x_err[i] = x_err[i] | perr[i]; x_rdata[i] = pdata[i]; pv[i] = 1'b0;
               end
            end
            x_ready[i] = (low_left[i] == 0);
         end
      end
   end

   int          total = 0;
   int          bad   = 0;
   logic        e_ready, e_rvalid, e_err;
   logic [31:0] e_rdata;
   logic [31:0] exp39 [4];

   task automatic lit(input string nm, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got %h want %h (t=%0t)", nm, got, want, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic w, input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
      valid = 1'b1; wr = w; addr = a; wdata = d; strb = s;
      tick();
      valid = 1'b0;
   endtask

   initial begin
      rst = 1'b1; valid = 1'b0; wr = 1'b0; addr = 8'h0; wdata = 32'h0; strb = 4'h0;
      exp39[0] = 32'hC0DE00FF; exp39[1] = 32'hC0DE01FE;
      exp39[2] = 32'hC0DE02FD; exp39[3] = 32'hC0DE03FC;

      fork
         forever begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
               e_ready  = rst ? 1'b0  : x_ready[i];
               e_rvalid = rst ? 1'b0  : x_rvalid[i];
               e_err    = rst ? 1'b0  : x_err[i];
               e_rdata  = rst ? 32'h0 : x_rdata[i];
               total++;
               if (ready[i] !== e_ready || rvalid[i] !== e_rvalid || err[i] !== e_err || rdata[i] !== e_rdata) begin
                  bad++;
                  $display("FAIL model_cmp dut%0d t=%0t: ready=%b rvalid=%b err=%b rdata=%h want ready=%b rvalid=%b err=%b rdata=%h",
                           i, $time, ready[i], rvalid[i], err[i], rdata[i], e_ready, e_rvalid, e_err, e_rdata);
               end
            end
         end
      join_none

      // reset state
      @(negedge clk);
      lit("rst_ready0", 32'(ready[0]), 32'h0);
      lit("rst_ready2", 32'(ready[2]), 32'h0);
      tick(); tick();
      rst = 1'b0;
      @(negedge clk);
      lit("post_rst_ready0", 32'(ready[0]), 32'h1);
      lit("post_rst_rvalid0", 32'(rvalid[0]), 32'h0);
      lit("post_rst_err0", 32'(err[0]), 32'h0);
      lit("post_rst_rdata0", rdata[0], 32'h0);

      for (int a = 0; a < 256; a++) drive(1'b1, 8'(a), pat(8'(a)), 4'hF);
      tick();

      // write then read back at latency 2 / 1 / 4
      drive(1'b1, 8'h10, 32'hDEADBEEF, 4'hF);
      drive(1'b0, 8'h10, 32'h0, 4'h0);
      @(negedge clk);
      lit("r36_ready0_low", 32'(ready[0]), 32'h0);
      lit("r36_rvalid0_early", 32'(rvalid[0]), 32'h0);
      lit("r36_rvalid1", 32'(rvalid[1]), 32'h1);
      lit("r36_rdata1", rdata[1], 32'hDEADBEEF);
      tick(); @(negedge clk);
      lit("r36_rvalid0", 32'(rvalid[0]), 32'h1);
      lit("r36_rdata0", rdata[0], 32'hDEADBEEF);
      lit("r36_err0", 32'(err[0]), 32'h0);
      lit("r36_ready0_back", 32'(ready[0]), 32'h1);
      lit("r36_rdata1_zero", rdata[1], 32'h0);
      tick(); @(negedge clk);
      lit("r36_rvalid2_early", 32'(rvalid[2]), 32'h0);
      tick(); @(negedge clk);
      lit("r36_rvalid2", 32'(rvalid[2]), 32'h1);
      lit("r36_rdata2", rdata[2], 32'hDEADBEEF);
      repeat (3) tick();

      // byte strobes
      drive(1'b1, 8'h05, 32'h11223344, 4'hF);
      drive(1'b1, 8'h05, 32'hAABBCCDD, 4'h5);
      drive(1'b0, 8'h05, 32'h0, 4'h0);
      @(negedge clk);
      lit("r37_rvalid1", 32'(rvalid[1]), 32'h1);
      lit("r37_rdata1", rdata[1], 32'h11BB33DD);
      tick(); @(negedge clk);
      lit("r37_rdata0", rdata[0], 32'h11BB33DD);
      repeat (5) tick();

      // out-of-range on the DEPTH=200 slave
      drive(1'b1, 8'hC8, 32'h12345678, 4'hF);
      @(negedge clk);
      lit("r38_werr0", 32'(err[0]), 32'h1);
      lit("r38_werr1", 32'(err[1]), 32'h0);
      tick(); @(negedge clk);
      lit("r38_werr0_pulse", 32'(err[0]), 32'h0);
      repeat (2) tick();
      drive(1'b0, 8'hC8, 32'h0, 4'h0);
      @(negedge clk);
      lit("r38_rerr0_early", 32'(err[0]), 32'h0);
      lit("r38_rdata1", rdata[1], 32'h12345678);
      tick(); @(negedge clk);
      lit("r38_rvalid0", 32'(rvalid[0]), 32'h1);
      lit("r38_rdata0", rdata[0], 32'h0);
      lit("r38_rerr0", 32'(err[0]), 32'h1);
      repeat (5) tick();
      drive(1'b0, 8'h48, 32'h0, 4'h0);
      tick(); @(negedge clk);
      lit("r38_alias0", rdata[0], 32'hC0DE48B7);
      repeat (5) tick();

      // back-to-back reads at latency 1
      for (int k = 0; k < 4; k++) begin
         drive(1'b0, 8'(k), 32'h0, 4'h0);
         @(negedge clk);
         lit("r39_rvalid1", 32'(rvalid[1]), 32'h1);
         lit("r39_rdata1", rdata[1], exp39[k]);
         lit("r39_ready1", 32'(ready[1]), 32'h1);
      end
      repeat (5) tick();

      // reset aborts an in-flight read
      drive(1'b0, 8'h10, 32'h0, 4'h0);
      rst = 1'b1;
      @(negedge clk);
      lit("r40_ready0_rst", 32'(ready[0]), 32'h0);
      lit("r40_ready1_rst", 32'(ready[1]), 32'h0);
      tick(); tick();
      rst = 1'b0;
      @(negedge clk);
      lit("r40_ready0", 32'(ready[0]), 32'h1);
      lit("r40_ready2", 32'(ready[2]), 32'h1);
      for (int k = 0; k < 5; k++) begin
         tick(); @(negedge clk);
         lit("r40_no_rvalid0", 32'(rvalid[0]), 32'h0);
         lit("r40_no_rvalid2", 32'(rvalid[2]), 32'h0);
      end
      drive(1'b0, 8'h10, 32'h0, 4'h0);
      @(negedge clk);
      lit("r40_retained1", rdata[1], 32'hDEADBEEF);
      repeat (5) tick();

      // randomized traffic, including boundary addresses and mid-stream resets
      for (int c = 0; c < 3000; c++) begin
         int sel;
         sel   = $urandom_range(0, 2);
         valid = ($urandom_range(0, 3) != 0);
         wr    = 1'($urandom_range(0, 1));
         if (sel == 0)      addr = 8'($urandom_range(0, 15));
         else if (sel == 1) addr = 8'($urandom_range(196, 203));
         else               addr = 8'($urandom_range(0, 255));
         wdata = $urandom;
         strb  = 4'($urandom);
         if (c == 1000 || c == 2000) rst = 1'b1;
         if (c == 1003 || c == 2003) rst = 1'b0;
         tick();
      end
      valid = 1'b0;
      repeat (8) tick();
      @(negedge clk);
      #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
